// File: rtl/l1_cache_pkg.sv
// Shared L1 cache definitions: line/beat geometry and the line-adapter state type.
package l1_cache_pkg;

    localparam int unsigned LINE_W   = 256;
    localparam int unsigned BURST_W  = 64;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned BEATS    = LINE_W / BURST_W;
    localparam int unsigned OFFSET_W = 5;
    localparam int unsigned BEAT_W   = $clog2(BEATS);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRdBurst = 2'd1,
        StWrBurst = 2'd2,
        StDone    = 2'd3
    } adapter_state_e;

endpackage

// File: rtl/l1_line_adapter.sv
// Converts line-granular L1 fills/write-backs into 64-bit memory bursts.
// Optional line counters are enabled with `define L1_ADAPTER_PERF_EN.
module l1_line_adapter
    import l1_cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                line_read,
    input  logic                line_write,
    input  logic [ADDR_W-1:0]   line_addr,
    input  logic [LINE_W-1:0]   line_wdata,
    output logic [LINE_W-1:0]   line_rdata,
    output logic                line_resp,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_read,
    output logic                mem_write,
    output logic [BURST_W-1:0]  mem_wdata,
    input  logic [BURST_W-1:0]  mem_rdata,
    input  logic                mem_resp,
    output logic [31:0]         perf_rd_lines,
    output logic [31:0]         perf_wr_lines
);

    adapter_state_e      state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   wbuf_q;
    logic [LINE_W-1:0]   rbuf_q;
    logic                accept;
    logic                last_beat;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^line_addr[OFFSET_W-1:0];

    assign accept    = (state_q == StIdle) && (line_read || line_write);
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                // Write-back takes priority; a pending fill is picked up after DONE.
                if (line_write) begin
                    state_d = StWrBurst;
                    beat_d  = '0;
                end else if (line_read) begin
                    state_d = StRdBurst;
                    beat_d  = '0;
                end
            end
            StRdBurst, StWrBurst: begin
                if (mem_resp) begin
                    if (last_beat) begin
                        state_d = StDone;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            beat_q  <= '0;
            addr_q  <= '0;
            wbuf_q  <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (accept) begin
                addr_q <= {line_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            end
            if ((state_q == StIdle) && line_write) begin
                wbuf_q <= line_wdata;
            end else if ((state_q == StWrBurst) && mem_resp) begin
                wbuf_q <= {{BURST_W{1'b0}}, wbuf_q[LINE_W-1:BURST_W]};
            end
            if ((state_q == StRdBurst) && mem_resp) begin
                for (int i = 0; i < BEATS; i++) begin
                    if (beat_q == BEAT_W'(i)) begin
                        rbuf_q[i*BURST_W +: BURST_W] <= mem_rdata;
                    end
                end
            end
        end
    end

    assign mem_addr   = addr_q;
    assign mem_read   = (state_q == StRdBurst);
    assign mem_write  = (state_q == StWrBurst);
    assign mem_wdata  = wbuf_q[BURST_W-1:0];
    assign line_resp  = (state_q == StDone);
    assign line_rdata = rbuf_q;

`ifdef L1_ADAPTER_PERF_EN
    logic [31:0] perf_rd_q, perf_wr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_rd_q <= '0;
            perf_wr_q <= '0;
        end else begin
            if ((state_q == StRdBurst) && (state_d == StDone)) perf_rd_q <= perf_rd_q + 32'd1;
            if ((state_q == StWrBurst) && (state_d == StDone)) perf_wr_q <= perf_wr_q + 32'd1;
        end
    end

    assign perf_rd_lines = perf_rd_q;
    assign perf_wr_lines = perf_wr_q;
`else
    assign perf_rd_lines = '0;
    assign perf_wr_lines = '0;
`endif

endmodule

// File: tb/tb_l1_line_adapter.sv
// Scoreboard bench for l1_line_adapter: expectations queued at request, checked at the memory/line side.
module tb_l1_line_adapter;
    import l1_cache_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                line_read, line_write;
    logic [ADDR_W-1:0]   line_addr;
    logic [LINE_W-1:0]   line_wdata;
    logic [LINE_W-1:0]   line_rdata;
    logic                line_resp;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_read, mem_write;
    logic [BURST_W-1:0]  mem_wdata;
    logic [BURST_W-1:0]  mem_rdata;
    logic                mem_resp;
    logic [31:0]         perf_rd_lines, perf_wr_lines;

    logic [ADDR_W-1:0]   exp_addr_q[$];
    logic [BURST_W-1:0]  exp_beat_q[$];
    logic [LINE_W-1:0]   exp_line_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int exp_rd   = 0;
    int exp_wr   = 0;
    logic [LINE_W-1:0] last_fill;

    l1_line_adapter u_dut (
        .clk           (clk),
        .rst           (rst),
        .line_read     (line_read),
        .line_write    (line_write),
        .line_addr     (line_addr),
        .line_wdata    (line_wdata),
        .line_rdata    (line_rdata),
        .line_resp     (line_resp),
        .mem_addr      (mem_addr),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_resp      (mem_resp),
        .perf_rd_lines (perf_rd_lines),
        .perf_wr_lines (perf_wr_lines)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                         input logic [LINE_W-1:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Entered and left at a negedge with the DUT idle. pat bit i is mem_resp in burst cycle i;
    // cycles beyond pat_len respond every cycle.
    task automatic run_burst(input bit wr, input logic [ADDR_W-1:0] addr,
                             input logic [LINE_W-1:0] line, input logic [15:0] pat,
                             input int pat_len, input bit hold_read);
        int  beats = 0;
        int  idx   = 0;
        bit  resp;
        line_write = wr;
        line_read  = !wr || hold_read;
        line_addr  = addr;
        line_wdata = wr ? line : rand_line();
        exp_addr_q.push_back({addr[ADDR_W-1:5], 5'b0});
        if (wr) begin
            for (int i = 0; i < BEATS; i++) exp_beat_q.push_back(line[i*BURST_W +: BURST_W]);
        end else begin
            exp_line_q.push_back(line);
        end
        @(negedge clk);
        line_write = 1'b0;
        line_read  = hold_read;
        line_addr  = $urandom;
        line_wdata = rand_line();
        check("mem_addr", mem_addr, exp_addr_q.pop_front());
        while (beats < BEATS) begin
            if (idx >= 64) begin
                check("burst_timeout", beats, BEATS);
                break;
            end
            resp      = (idx < pat_len) ? pat[idx] : 1'b1;
            idx++;
            mem_resp  = resp;
            mem_rdata = (!wr && resp) ? line[beats*BURST_W +: BURST_W] : {$urandom, $urandom};
            check(wr ? "wr_busy" : "rd_busy", {mem_read, mem_write, line_resp},
                  wr ? 3'b010 : 3'b100);
            if (wr && resp) check("mem_wdata", mem_wdata, exp_beat_q.pop_front());
            if (resp) beats++;
            @(negedge clk);
        end
        mem_resp = 1'b0;
        check("done", {mem_read, mem_write, line_resp}, 3'b001);
        if (!wr) begin
            check("line_rdata", line_rdata, exp_line_q.pop_front());
            last_fill = line;
            exp_rd++;
        end else begin
            exp_wr++;
        end
        @(negedge clk);
        check("idle", {mem_read, mem_write, line_resp}, 3'b000);
        check("rdata_held", line_rdata, last_fill);
    endtask

    task automatic check_perf(input string tag);
`ifdef L1_ADAPTER_PERF_EN
        check({tag, "_rd"}, perf_rd_lines, exp_rd);
        check({tag, "_wr"}, perf_wr_lines, exp_wr);
`else
        check({tag, "_rd"}, perf_rd_lines, 0);
        check({tag, "_wr"}, perf_wr_lines, 0);
`endif
    endtask

    initial begin
        rst        = 1'b0;
        line_read  = 1'b0;
        line_write = 1'b0;
        line_addr  = '0;
        line_wdata = '0;
        mem_rdata  = '0;
        mem_resp   = 1'b0;
        last_fill  = '0;
        #1;
        check("rst_ctl", {mem_read, mem_write, line_resp}, 3'b000);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", line_rdata, 0);
        check_perf("rst_perf");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Fill with back-to-back beats.
        run_burst(1'b0, 32'h0000_1234,
                  {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 16'h0, 0, 1'b0);

        // Stray mem_resp while idle must not start anything.
        mem_resp = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_resp", {mem_read, mem_write, line_resp}, 3'b000);
        check("idle_resp_rdata", line_rdata, last_fill);
        mem_resp = 1'b0;

        // Write-back: beats A, B, C, D.
        run_burst(1'b1, 32'h8000_00FF,
                  {64'hDDDD_0000_DDDD_0004, 64'hCCCC_0000_CCCC_0003,
                   64'hBBBB_0000_BBBB_0002, 64'hAAAA_0000_AAAA_0001}, 16'h0, 0, 1'b0);

        // Stalled fill: mem_resp 1,0,0,1,1,0,1.
        run_burst(1'b0, 32'h0ACE_0040, rand_line(), 16'h0059, 7, 1'b0);

        // Stalled write-back.
        run_burst(1'b1, 32'h1234_567F, rand_line(), 16'h00A5, 8, 1'b0);

        // Simultaneous read and write: write first, read accepted right after DONE.
        run_burst(1'b1, 32'h0000_2000, rand_line(), 16'h0, 0, 1'b1);
        run_burst(1'b0, 32'h0000_3010, rand_line(), 16'h0, 0, 1'b0);
        check_perf("perf_mid");

        // Reset during beat 2 of a fill.
        line_read = 1'b1;
        line_addr = 32'h5555_5555;
        @(negedge clk);
        line_read = 1'b0;
        mem_resp  = 1'b1;
        mem_rdata = 64'hFEED_FACE_0000_0001;
        @(negedge clk);
        mem_rdata = 64'hFEED_FACE_0000_0002;
        @(negedge clk);
        mem_resp  = 1'b0;
        rst       = 1'b0;
        #1;
        check("rst_mid_ctl", {mem_read, mem_write, line_resp}, 3'b000);
        check("rst_mid_addr", mem_addr, 0);
        check("rst_mid_rdata", line_rdata, 0);
        exp_rd    = 0;
        exp_wr    = 0;
        last_fill = '0;
        check_perf("rst_mid_perf");
        @(negedge clk);
        rst = 1'b1;
        check("rst_no_resp", line_resp, 1'b0);
        @(negedge clk);
        check("post_rst_idle", {mem_read, mem_write, line_resp}, 3'b000);

        run_burst(1'b0, 32'h0000_4444, rand_line(), 16'h0005, 4, 1'b0);
        check_perf("perf_end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule
